// File: rtl/sliding_detector_sequencer.sv
// Shares a bank of num_units slice units across all width positions of a frame, one group
// per cycle, and assembles the per-position flags/energies behind a valid/ready handshake.
module sliding_detector_sequencer #(
  parameter int unsigned width                = 16,
  parameter int unsigned num_units            = 4,
  parameter int unsigned unit_latency         = 2,
  parameter int unsigned num_of_flip_patterns = 4,
  parameter int unsigned ener_bitwidth        = 18,
  localparam int unsigned FW = $clog2(num_of_flip_patterns + 1),
  localparam int unsigned G  = width / num_units,
  localparam int unsigned GW = (G > 1) ? $clog2(G) : 1,
  localparam int unsigned CW = $clog2(width + 1)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  output logic                                      busy,
  output logic                                      grp_issue,
  output logic [GW-1:0]                             grp_sel,
  input  logic [num_units-1:0][FW-1:0]              unit_err_flags,
  input  logic [num_units-1:0][ener_bitwidth-1:0]   unit_mmse_vals,
  output logic [width-1:0][FW-1:0]                  err_flags,
  output logic [width-1:0][ener_bitwidth-1:0]       mmse_vals,
  output logic [CW-1:0]                             flag_count,
  output logic                                      res_valid,
  input  logic                                      res_ready
);

  if ((width % num_units) != 0) begin : g_bad_width
    $error("width must be a multiple of num_units");
  end
  if (unit_latency < 1) begin : g_bad_latency
    $error("unit_latency must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StHold} state_e;

  localparam logic [GW-1:0] LastGrp = GW'(G - 1);

  state_e                                 state_q, state_d;
  logic [GW-1:0]                          cnt_q;
  logic [unit_latency-1:0]                pipe_vld_q;
  logic [unit_latency-1:0][GW-1:0]        pipe_grp_q;
  logic [width-1:0][FW-1:0]               err_q;
  logic [width-1:0][ener_bitwidth-1:0]    mmse_q;
  logic [CW-1:0]                          count_q;
  logic                                   tail_vld;
  logic [GW-1:0]                          tail_grp;
  logic [CW-1:0]                          cap_count;
  logic                                   start_acc;

  assign tail_vld   = pipe_vld_q[unit_latency-1];
  assign tail_grp   = pipe_grp_q[unit_latency-1];
  assign start_acc  = (state_q == StIdle) && start;
  assign busy       = (state_q != StIdle);
  assign err_flags  = err_q;
  assign mmse_vals  = mmse_q;
  assign flag_count = count_q;

  always_comb begin
    state_d   = state_q;
    grp_issue = 1'b0;
    grp_sel   = '0;
    res_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StIssue;
      end
      StIssue: begin
        grp_issue = 1'b1;
        grp_sel   = cnt_q;
        if (cnt_q == LastGrp) state_d = StDrain;
      end
      StDrain: begin
        if (tail_vld && (tail_grp == LastGrp)) state_d = StHold;
      end
      StHold: begin
        res_valid = 1'b1;
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Number of nonzero flags returned by the bank this cycle.
  always_comb begin
    cap_count = '0;
    for (int k = 0; k < int'(num_units); k++) begin
      if (unit_err_flags[k] != '0) cap_count = cap_count + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      pipe_vld_q <= '0;
      pipe_grp_q <= '0;
      err_q      <= '0;
      mmse_q     <= '0;
      count_q    <= '0;
    end else begin
      // Delay line tracks which group the bank is answering for.
      pipe_vld_q[0] <= grp_issue;
      pipe_grp_q[0] <= cnt_q;
      for (int i = 1; i < int'(unit_latency); i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_grp_q[i] <= pipe_grp_q[i-1];
      end
      if (start_acc) begin
        cnt_q   <= '0;
        err_q   <= '0;
        mmse_q  <= '0;
        count_q <= '0;
      end else begin
        if (grp_issue && (cnt_q != LastGrp)) cnt_q <= cnt_q + GW'(1);
        if (tail_vld) begin
          for (int p = 0; p < int'(width); p++) begin
            if (tail_grp == GW'(p / int'(num_units))) begin
              err_q[p]  <= unit_err_flags[p % int'(num_units)];
              mmse_q[p] <= unit_mmse_vals[p % int'(num_units)];
            end
          end
          count_q <= count_q + cap_count;
        end
      end
    end
  end

endmodule

// File: tb/tb_sliding_detector_sequencer.sv
// Randomized scoreboard bench: a frame-level model predicts timing and assembled results;
// a slice-bank model answers issued groups after the unit latency.
module tb_sliding_detector_sequencer;

  localparam int W = 16, N = 4, L = 2, NF = 4, EB = 18;
  localparam int FW = 3, G = 4, GW = 2, CW = 5;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, res_ready = 1'b0;
  logic busy, grp_issue, res_valid;
  logic [GW-1:0] grp_sel;
  logic [N-1:0][FW-1:0] unit_err_flags = '0;
  logic [N-1:0][EB-1:0] unit_mmse_vals = '0;
  logic [W-1:0][FW-1:0] err_flags;
  logic [W-1:0][EB-1:0] mmse_vals;
  logic [CW-1:0] flag_count;

  // Single-group and two-group configurations.
  logic g1_start = 1'b0;
  logic g1_busy, g1_issue, g1_valid, g2_busy, g2_issue, g2_valid;
  logic [0:0] g1_sel, g2_sel;
  logic [15:0][FW-1:0] g1_uerr, g1_err, g2_err;
  logic [15:0][EB-1:0] g1_umm, g1_mmse, g2_mmse;
  logic [7:0][FW-1:0] g2_uerr;
  logic [7:0][EB-1:0] g2_umm;
  logic [CW-1:0] g1_count, g2_count;

  sliding_detector_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .grp_issue(grp_issue),
    .grp_sel(grp_sel), .unit_err_flags(unit_err_flags), .unit_mmse_vals(unit_mmse_vals),
    .err_flags(err_flags), .mmse_vals(mmse_vals), .flag_count(flag_count),
    .res_valid(res_valid), .res_ready(res_ready)
  );

  sliding_detector_sequencer #(.width(16), .num_units(16), .unit_latency(3)) u_dut_g1 (
    .clk(clk), .rst(rst), .start(g1_start), .busy(g1_busy), .grp_issue(g1_issue),
    .grp_sel(g1_sel), .unit_err_flags(g1_uerr), .unit_mmse_vals(g1_umm),
    .err_flags(g1_err), .mmse_vals(g1_mmse), .flag_count(g1_count),
    .res_valid(g1_valid), .res_ready(1'b1)
  );

  sliding_detector_sequencer #(.width(16), .num_units(8), .unit_latency(1)) u_dut_g2 (
    .clk(clk), .rst(rst), .start(g1_start), .busy(g2_busy), .grp_issue(g2_issue),
    .grp_sel(g2_sel), .unit_err_flags(g2_uerr), .unit_mmse_vals(g2_umm),
    .err_flags(g2_err), .mmse_vals(g2_mmse), .flag_count(g2_count),
    .res_valid(g2_valid), .res_ready(1'b1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  typedef struct packed {
    logic [W-1:0][FW-1:0] err;
    logic [W-1:0][EB-1:0] mmse;
    logic [CW-1:0]        cnt;
  } res_t;
  typedef struct packed {
    logic          iss;
    logic [GW-1:0] sel;
  } hist_t;

  res_t sb[$];
  res_t last = '0;
  hist_t hist[$];
  logic [FW-1:0] tbl_err [G][N];
  logic [EB-1:0] tbl_mmse [G][N];
  bit m_busy = 0;
  bit directed = 0;
  int m_s = 0, iss_cnt = 0;

  // Frame-level model, scoreboard and slice-bank responder.
  initial begin : monitor
    int r;
    res_t e;
    hist_t h;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_issue", 512'(grp_issue), 512'(0));
        chk("rst_valid", 512'(res_valid), 512'(0));
        chk("rst_sel", 512'(grp_sel), 512'(0));
        chk("rst_flags", 512'(err_flags), 512'(0));
        chk("rst_mmse", 512'(mmse_vals), 512'(0));
        chk("rst_count", 512'(flag_count), 512'(0));
        m_busy = 0;
        sb.delete();
        last = '0;
      end else if (!m_busy) begin
        chk("idle_busy", 512'(busy), 512'(0));
        chk("idle_issue", 512'(grp_issue), 512'(0));
        chk("idle_valid", 512'(res_valid), 512'(0));
        chk("idle_flags", 512'(err_flags), 512'(last.err));
        chk("idle_mmse", 512'(mmse_vals), 512'(last.mmse));
        chk("idle_count", 512'(flag_count), 512'(last.cnt));
        if (start) begin
          m_busy = 1;
          m_s = cyc;
          iss_cnt = 0;
          e = '0;
          for (int g = 0; g < G; g++) begin
            for (int k = 0; k < N; k++) begin
              if (directed) begin
                tbl_err[g][k]  = (k == 0) ? FW'(1) : (k == 2) ? FW'(3) : FW'(0);
                tbl_mmse[g][k] = EB'(100 * g + k);
              end else begin
                tbl_err[g][k]  = ($urandom % 2 == 1) ? FW'($urandom_range(1, NF)) : FW'(0);
                tbl_mmse[g][k] = EB'($urandom);
              end
              e.err[g*N+k]  = tbl_err[g][k];
              e.mmse[g*N+k] = tbl_mmse[g][k];
              if (tbl_err[g][k] != 0) e.cnt = e.cnt + 1'b1;
            end
          end
          sb.push_back(e);
        end
      end else begin
        r = cyc - m_s;
        chk("busy", 512'(busy), 512'(1));
        chk("grp_issue", 512'(grp_issue), 512'((r >= 1 && r <= G) ? 1 : 0));
        if (r >= 1 && r <= G) chk("grp_sel", 512'(grp_sel), 512'(r - 1));
        if (grp_issue) iss_cnt++;
        chk("res_valid", 512'(res_valid), 512'((r >= G + L + 1) ? 1 : 0));
        if (r == 1) begin
          chk("clear_flags", 512'(err_flags), 512'(0));
          chk("clear_mmse", 512'(mmse_vals), 512'(0));
          chk("clear_count", 512'(flag_count), 512'(0));
        end
        if (r >= G + L + 1) begin
          chk("sb_nonempty", 512'(sb.size() > 0), 512'(1));
          if (sb.size() > 0) begin
            e = sb[0];
            chk("res_flags", 512'(err_flags), 512'(e.err));
            chk("res_mmse", 512'(mmse_vals), 512'(e.mmse));
            chk("res_count", 512'(flag_count), 512'(e.cnt));
            if (res_ready) begin
              chk("issue_count", 512'(iss_cnt), 512'(G));
              last = sb.pop_front();
              m_busy = 0;
            end
          end
        end
      end
      hist.push_back({grp_issue, grp_sel});
      h = '0;
      if (hist.size() > L) h = hist.pop_front();
      for (int k = 0; k < N; k++) begin
        if (h.iss) begin
          unit_err_flags[k] = tbl_err[h.sel][k];
          unit_mmse_vals[k] = tbl_mmse[h.sel][k];
        end else begin
          unit_err_flags[k] = FW'($urandom);
          unit_mmse_vals[k] = EB'($urandom);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(nm, 512'(res_valid), 512'(1));
  endtask

  initial begin : stimulus
    int c0;
    int i1_n, i1_first, v1_first, i2_n, v2_first;
    logic [15:0][FW-1:0] e1, e2;
    logic [15:0][EB-1:0] m1;
    for (int k = 0; k < 16; k++) begin
      g1_uerr[k] = FW'(k % 5);
      g1_umm[k]  = EB'(1000 + k);
    end
    for (int k = 0; k < 8; k++) begin
      g2_uerr[k] = FW'(k % 5);
      g2_umm[k]  = EB'(k);
    end
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Nominal directed frame.
    directed = 1;
    start = 1'b1; res_ready = 1'b1; c0 = cyc;
    tick();
    start = 1'b0;
    wait_valid("nom_wait");
    chk("nom_valid_cycle", 512'(cyc - c0), 512'(7));
    chk("nom_mmse9", 512'(mmse_vals[9]), 512'(201));
    chk("nom_count", 512'(flag_count), 512'(8));
    tick();
    directed = 0;

    // Backpressure for 10 cycles in HOLD.
    res_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("bp_wait");
    repeat (10) tick();
    chk("bp_held", 512'(res_valid), 512'(1));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_release_valid", 512'(res_valid), 512'(0));
    chk("bp_release_busy", 512'(busy), 512'(0));
    tick();

    // Start pulses while busy and in the handshake cycle.
    start = 1'b1; tick();
    start = 1'b0; tick();
    start = 1'b1; tick();
    start = 1'b0; tick(); tick();
    start = 1'b1; tick();
    start = 1'b0;
    wait_valid("busy_wait");
    start = 1'b1; res_ready = 1'b1;
    tick();
    start = 1'b0; res_ready = 1'b0;
    chk("busy_no_restart", 512'(busy), 512'(0));
    tick(); tick();
    chk("busy_not_queued", 512'(busy), 512'(0));

    // Reset mid-frame, after the first capture.
    directed = 1;
    start = 1'b1; tick();
    start = 1'b0; tick(); tick(); tick();
    chk("pre_rst_count", 512'(flag_count), 512'(2));
    rst = 1'b1;
    #1;
    chk("rst_async_count", 512'(flag_count), 512'(0));
    chk("rst_async_busy", 512'(busy), 512'(0));
    tick();
    rst = 1'b0; directed = 0;
    tick();
    start = 1'b1; res_ready = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("post_rst_wait");
    tick();

    // Back-to-back frames.
    start = 1'b1; tick();
    start = 1'b0;
    wait_valid("b2b_wait1");
    tick();
    start = 1'b1; c0 = cyc;
    tick();
    start = 1'b0;
    wait_valid("b2b_wait2");
    chk("b2b_valid_cycle", 512'(cyc - c0), 512'(7));
    tick();

    // Random traffic with occasional resets.
    repeat (800) begin
      start = ($urandom % 6 == 0);
      res_ready = $urandom % 2;
      rst = ($urandom % 300 == 0);
      tick();
    end
    rst = 1'b0; start = 1'b0; res_ready = 1'b1;
    repeat (20) tick();

    // Single-group and two-group configurations.
    i1_n = 0; i1_first = -1; v1_first = -1; i2_n = 0; v2_first = -1;
    g1_start = 1'b1;
    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      if (g1_issue) begin
        i1_n++;
        if (i1_first < 0) i1_first = r;
      end
      if (g1_valid && v1_first < 0) v1_first = r;
      if (g2_issue) i2_n++;
      if (g2_valid && v2_first < 0) v2_first = r;
      tick();
      g1_start = 1'b0;
    end
    for (int p = 0; p < 16; p++) begin
      e1[p] = FW'(p % 5);
      e2[p] = FW'((p % 8) % 5);
      m1[p] = EB'(1000 + p);
    end
    chk("g1_issue_cycles", 512'(i1_n), 512'(1));
    chk("g1_issue_first", 512'(i1_first), 512'(1));
    chk("g1_valid_cycle", 512'(v1_first), 512'(5));
    chk("g1_flags", 512'(g1_err), 512'(e1));
    chk("g1_mmse", 512'(g1_mmse), 512'(m1));
    chk("g1_count", 512'(g1_count), 512'(12));
    chk("g2_issue_cycles", 512'(i2_n), 512'(2));
    chk("g2_valid_cycle", 512'(v2_first), 512'(4));
    chk("g2_flags", 512'(g2_err), 512'(e2));
    chk("g2_count", 512'(g2_count), 512'(12));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
